ifu_imem_fetch: RTL

- Fetch-memory stage directly downstream of the PC-generating IFU.
- Accepts the current PC with a valid/ready handshake and issues one 8-byte-aligned read to instruction memory.
- Selects the 32-bit instruction word from the 64-bit response and presents {pc, inst, fault} to decode with a valid/ready handshake.
- Handles redirects (branch, exception, mret) arriving mid-transaction by discarding in-flight work; at most one memory request is outstanding.

---
 rtl/ifu_imem_fetch.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ifu_imem_fetch.sv
// ---------------------------------------------------------------------------
// ifu_imem_fetch
//
// Fetch-memory stage sitting directly behind the PC generator. It takes one
// PC at a time, issues a single 8-byte-aligned read to instruction memory,
// picks the 32-bit word addressed by pc[2] out of the 64-bit response and
// hands {pc, inst, fault} to decode. A redirect (flush_i) throws away any
// in-flight work. At most one memory request is ever outstanding, so a
// request that was already accepted by memory is drained before the stage
// goes idle again.
//
// Optional feature macro: IFU_FETCH_ALIGN_CHECK_EN
//   defined   : a PC with pc[1:0] != 0 skips memory and is reported as a
//               fetch fault (inst = RESET_FAULT_INST) on the next cycle
//   undefined : pc[1:0] is ignored, every PC issues a memory read
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   pc_i/pc_valid_i     PC from the IFU and its valid
//   pc_ready_o          stage can take pc_i this cycle
//   flush_i             redirect, kill everything in flight
//   imem_req_*          read request channel (valid/ready, aligned address)
//   imem_resp_*         read response (valid, 64-bit data, access error)
//   out_valid_o/ready_i handshake towards decode
//   out_pc_o/inst_o     PC and instruction word presented to decode
//   out_fault_o         fetch fault for the presented PC
// ---------------------------------------------------------------------------
module ifu_imem_fetch #(
  parameter logic [31:0] RESET_FAULT_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_valid_o,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [63:0] imem_resp_data_i,
  input  logic        imem_resp_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        out_fault_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_next;
  logic        fault_q;
  logic        fault_next;
  logic        load_result;
  logic        accept;
  logic        misaligned;

  // A new PC can enter when the stage is empty, or when the held result is
  // leaving this very cycle (back-to-back fetch). A flush blocks the
  // back-to-back path because the held result is being discarded instead.
  assign pc_ready_o = (state == IDLE) ||
                      ((state == HOLD) && out_ready_i && !flush_i);
  assign accept     = pc_valid_i && pc_ready_o && !flush_i;

`ifdef IFU_FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign imem_req_valid_o = (state == REQ);
  assign imem_req_addr_o  = {pc_q[63:3], 3'b000};
  assign out_valid_o      = (state == HOLD) && !flush_i;
  assign out_pc_o         = pc_q;
  assign out_inst_o       = inst_q;
  assign out_fault_o      = fault_q;

  // Next-state and result-capture logic. A flush that lands after memory
  // has taken the request must still swallow the matching response, which
  // is what DRAIN is for; if that response shows up in the same cycle as
  // the flush there is nothing left to wait for and we go straight to IDLE.
  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    inst_next   = inst_q;
    fault_next  = fault_q;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next = misaligned ? HOLD : REQ;
        end
      end

      REQ: begin
        if (imem_req_ready_i) begin
          state_next = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          state_next = IDLE;
        end
      end

      WAIT: begin
        if (flush_i) begin
          state_next = imem_resp_valid_i ? IDLE : DRAIN;
        end else if (imem_resp_valid_i) begin
          state_next  = HOLD;
          load_result = 1'b1;
          fault_next  = imem_resp_err_i;
          if (imem_resp_err_i) begin
            inst_next = RESET_FAULT_INST;
          end else if (pc_q[2]) begin
            inst_next = imem_resp_data_i[63:32];
          end else begin
            inst_next = imem_resp_data_i[31:0];
          end
        end
      end

      DRAIN: begin
        if (imem_resp_valid_i) begin
          state_next = IDLE;
        end
      end

      HOLD: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (out_ready_i) begin
          if (accept) begin
            state_next = misaligned ? HOLD : REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A misaligned PC (only possible with the alignment check built in)
    // produces its fault result immediately instead of going to memory.
    if (accept && misaligned) begin
      load_result = 1'b1;
      inst_next   = RESET_FAULT_INST;
      fault_next  = 1'b1;
    end
  end

  // State register plus the PC and result registers that drive decode.
  // They only change on an accept or on a captured response, which keeps
  // the decode-facing outputs stable for as long as HOLD is presenting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        pc_q <= pc_i;
      end
      if (load_result) begin
        inst_q  <= inst_next;
        fault_q <= fault_next;
      end
    end
  end

  // Memory may only answer a request it actually accepted, which can only
  // be outstanding in WAIT or DRAIN. Anything else is ignored by the logic
  // above and flagged here in simulation.
  resp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (reset)
      imem_resp_valid_i |-> ((state == WAIT) || (state == DRAIN))
  );

endmodule
